// File: rtl/led_blink_bank.sv
// rtl/led_blink_bank.sv - multi-channel LED blinker with off/on/blink/burst modes and runtime config port
module led_blink_bank #(
    parameter int CHANNELS     = 4,
    parameter int CNT_WIDTH    = 26,
    parameter int DEFAULT_HALF = 25000000,
    parameter int DEFAULT_MODE = 2,
    parameter int PAUSE_HALVES = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [3:0]           cfg_chan,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_WIDTH-1:0] cfg_half,
    input  logic [3:0]           cfg_burst,
    input  logic                 sync_restart,
    output logic [CHANNELS-1:0]  LED,
    output logic [CHANNELS-1:0]  wrap_pulse
);

    // Wide enough that PAUSE_HALVES * H cannot overflow for PAUSE_HALVES <= 15.
    localparam int CW = CNT_WIDTH + 4;

    typedef enum logic {ST_BLINK, ST_PAUSE} burst_state_t;

    logic cfg_accept;
    assign cfg_accept = cfg_valid && cfg_ready;

    // Config port takes one write, then rests for exactly one cycle.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= !cfg_accept;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [CW-1:0]        cnt;
        logic [CNT_WIDTH-1:0] half;
        logic [1:0]           mode;
        logic [3:0]           burst_len;
        burst_state_t         state;
        logic [4:0]           burst_cnt;
        logic                 led_q;
        logic                 wrap_q;

        logic [CNT_WIDTH-1:0] h_eff;
        logic [CW-1:0]        h_last;
        logic [CW-1:0]        pause_last;
        logic [4:0]           toggles_last;
        logic                 hit;
        logic                 half_done;
        logic                 pause_done;
        logic                 burst_done;

        // Terminal counts: half=0 acts as 1, burst_len=0 acts as 1.
        always_comb begin
            h_eff        = (half == '0) ? CNT_WIDTH'(1) : half;
            h_last       = CW'(h_eff) - CW'(1);
            pause_last   = CW'(PAUSE_HALVES) * CW'(h_eff) - CW'(1);
            toggles_last = (burst_len == 4'd0) ? 5'd1 : ({burst_len, 1'b0} - 5'd1);
            hit          = cfg_accept && (cfg_chan == 4'(g));
            half_done    = (cnt == h_last);
            pause_done   = (cnt == pause_last);
            burst_done   = (burst_cnt == toggles_last);
        end

        // Per-channel counter, mode handling and burst/pause state machine.
        always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
                cnt       <= '0;
                half      <= CNT_WIDTH'(DEFAULT_HALF);
                mode      <= 2'(DEFAULT_MODE);
                burst_len <= 4'd1;
                state     <= ST_BLINK;
                burst_cnt <= '0;
                led_q     <= 1'b0;
                wrap_q    <= 1'b0;
            end else begin
                if (hit) begin
                    mode      <= cfg_mode;
                    half      <= cfg_half;
                    burst_len <= cfg_burst;
                end
                // A write and a restart both re-phase the channel from zero.
                if (hit || sync_restart) begin
                    cnt       <= '0;
                    led_q     <= 1'b0;
                    burst_cnt <= '0;
                    state     <= ST_BLINK;
                    wrap_q    <= 1'b0;
                end else begin
                    wrap_q <= 1'b0;
                    case (mode)
                        2'd0: begin
                            cnt   <= '0;
                            led_q <= 1'b0;
                        end
                        2'd1: begin
                            cnt   <= '0;
                            led_q <= 1'b1;
                        end
                        2'd2: begin
                            if (half_done) begin
                                cnt    <= '0;
                                led_q  <= !led_q;
                                wrap_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        default: begin
                            if (state == ST_BLINK) begin
                                if (half_done) begin
                                    cnt    <= '0;
                                    led_q  <= !led_q;
                                    wrap_q <= 1'b1;
                                    // Even toggle count, so the LED lands at 0 entering the pause.
                                    if (burst_done) begin
                                        burst_cnt <= '0;
                                        state     <= ST_PAUSE;
                                    end else begin
                                        burst_cnt <= burst_cnt + 5'd1;
                                    end
                                end else begin
                                    cnt <= cnt + CW'(1);
                                end
                            end else begin
                                led_q <= 1'b0;
                                if (pause_done) begin
                                    cnt   <= '0;
                                    state <= ST_BLINK;
                                end else begin
                                    cnt <= cnt + CW'(1);
                                end
                            end
                        end
                    endcase
                end
            end
        end

        assign LED[g]        = led_q;
        assign wrap_pulse[g] = wrap_q;
    end

endmodule

// File: tb/tb_led_blink_bank.sv
// tb/tb_led_blink_bank.sv - randomized self-checking bench for led_blink_bank against a phase-time model
module tb_led_blink_bank;

    localparam int NCH   = 4;
    localparam int CW    = 10;
    localparam int PAUSE = 8;

    logic          clk;
    logic          reset_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [3:0]    cfg_chan;
    logic [1:0]    cfg_mode;
    logic [CW-1:0] cfg_half;
    logic [3:0]    cfg_burst;
    logic          sync_restart;
    logic [NCH-1:0] LED;
    logic [NCH-1:0] wrap_pulse;

    led_blink_bank #(
        .CHANNELS(NCH), .CNT_WIDTH(CW), .DEFAULT_HALF(5), .DEFAULT_MODE(2), .PAUSE_HALVES(PAUSE)
    ) dut (
        .CLOCK_50(clk), .reset(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_burst(cfg_burst),
        .sync_restart(sync_restart), .LED(LED), .wrap_pulse(wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each channel is described by its settings and the number of
    // clock edges since it was last (re)started; outputs follow from that.
    int m_mode[NCH];
    int m_half[NCH];
    int m_burst[NCH];
    int m_t[NCH];
    bit m_ready;

    function automatic void model_init();
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 2; m_half[i] = 5; m_burst[i] = 1; m_t[i] = 0;
        end
        m_ready = 1'b0;
    endfunction

    function automatic bit m_led(int ch);
        int h, bl, c, u, n;
        h  = (m_half[ch] == 0) ? 1 : m_half[ch];
        bl = (m_burst[ch] == 0) ? 1 : m_burst[ch];
        case (m_mode[ch])
            0: return 1'b0;
            1: return m_t[ch] >= 1;
            2: return ((m_t[ch] / h) % 2) == 1;
            default: begin
                c = (2 * bl + PAUSE) * h;
                u = m_t[ch] % c;
                n = u / h;
                return (n < 2 * bl) && (n % 2 == 1);
            end
        endcase
    endfunction

    function automatic bit m_wrap(int ch);
        int h, bl, c, u, n;
        h  = (m_half[ch] == 0) ? 1 : m_half[ch];
        bl = (m_burst[ch] == 0) ? 1 : m_burst[ch];
        if (m_t[ch] == 0) return 1'b0;
        case (m_mode[ch])
            0, 1: return 1'b0;
            2: return (m_t[ch] % h) == 0;
            default: begin
                c = (2 * bl + PAUSE) * h;
                u = m_t[ch] % c;
                n = u / h;
                return (u % h == 0) && (n >= 1) && (n <= 2 * bl);
            end
        endcase
    endfunction

    function automatic logic [NCH-1:0] m_led_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_led(i);
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_wrap_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_wrap(i);
        return v;
    endfunction

    // One clock edge: advance the model with the inputs present at the edge, then sample point.
    task automatic tick();
        bit acc;
        acc = cfg_valid && m_ready;
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (acc && (int'(cfg_chan) == i)) begin
                m_mode[i] = int'(cfg_mode); m_half[i] = int'(cfg_half);
                m_burst[i] = int'(cfg_burst); m_t[i] = 0;
            end else if (sync_restart) begin
                m_t[i] = 0;
            end else begin
                m_t[i]++;
            end
        end
        m_ready = !acc;
        #1;
    endtask

    task automatic cfg_write(input int ch, input int md, input int hf, input int bs);
        if (!m_ready) tick();
        cfg_valid = 1'b1; cfg_chan = 4'(ch); cfg_mode = 2'(md);
        cfg_half = CW'(hf); cfg_burst = 4'(bs);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        int first_rise;
        first_rise = -1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (LED !== '0 || wrap_pulse !== '0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state LED=%b wrap=%b ready=%b expected 0 0 0", LED, wrap_pulse, cfg_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_init();
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 1) begin
                n_tests++;
                if (cfg_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_ready_after_release ready=%b expected 1", cfg_ready);
                end
            end
            if (first_rise < 0 && LED[0] === 1'b1) first_rise = k;
            n_tests++;
            if (LED !== m_led_vec() || wrap_pulse !== m_wrap_vec()) begin
                n_fail++;
                $display("FAIL reset_default_blink cyc%0d LED=%b wrap=%b expected LED=%b wrap=%b",
                         k, LED, wrap_pulse, m_led_vec(), m_wrap_vec());
            end
        end
        n_tests++;
        if (first_rise != 5) begin
            n_fail++;
            $display("FAIL reset_first_rise got cycle %0d expected 5", first_rise);
        end
    endtask

    task automatic test_static_modes();
        logic prev3;
        cfg_write(1, 1, 5, 1);
        cfg_write(2, 0, 5, 1);
        cfg_write(3, 2, 0, 1);
        prev3 = LED[3];
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++;
            if (LED[1] !== 1'b1 || LED[2] !== 1'b0 || wrap_pulse[2] !== 1'b0 || LED[3] === prev3) begin
                n_fail++;
                $display("FAIL static_modes cyc%0d LED=%b wrap=%b expected LED[1]=1 LED[2]=0 wrap[2]=0 LED[3]!=%b",
                         k, LED, wrap_pulse, prev3);
            end
            n_tests++;
            if (LED !== m_led_vec() || wrap_pulse !== m_wrap_vec()) begin
                n_fail++;
                $display("FAIL static_modes_model cyc%0d LED=%b wrap=%b expected LED=%b wrap=%b",
                         k, LED, wrap_pulse, m_led_vec(), m_wrap_vec());
            end
            prev3 = LED[3];
        end
    endtask

    task automatic test_burst();
        int pulses;
        pulses = 0;
        cfg_write(0, 3, 2, 2);
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k <= 8 && wrap_pulse[0] === 1'b1) pulses++;
            if (k >= 9 && k <= 24) begin
                n_tests++;
                if (LED[0] !== 1'b0 || wrap_pulse[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL burst_pause cyc%0d LED0=%b wrap0=%b expected 0 0", k, LED[0], wrap_pulse[0]);
                end
            end
            if (k == 26) begin
                n_tests++;
                if (LED[0] !== 1'b1 || wrap_pulse[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL burst_repeat LED0=%b wrap0=%b expected 1 1", LED[0], wrap_pulse[0]);
                end
            end
            n_tests++;
            if (LED !== m_led_vec() || wrap_pulse !== m_wrap_vec()) begin
                n_fail++;
                $display("FAIL burst_model cyc%0d LED=%b wrap=%b expected LED=%b wrap=%b",
                         k, LED, wrap_pulse, m_led_vec(), m_wrap_vec());
            end
        end
        n_tests++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL burst_toggle_count got %0d expected 4", pulses);
        end
    endtask

    task automatic test_handshake();
        logic exp_rdy;
        if (!m_ready) tick();
        cfg_valid = 1'b1; cfg_chan = 4'd2; cfg_mode = 2'd2; cfg_half = CW'(3); cfg_burst = 4'd1;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0);
            n_tests++;
            if (cfg_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL handshake_ready step%0d ready=%b expected %b", k, cfg_ready, exp_rdy);
            end
            tick();
        end
        cfg_valid = 1'b0;
        cfg_write(9, 1, 7, 3);
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_tests++;
            if (LED !== m_led_vec() || wrap_pulse !== m_wrap_vec() || cfg_ready !== m_ready) begin
                n_fail++;
                $display("FAIL handshake_model cyc%0d LED=%b wrap=%b ready=%b expected LED=%b wrap=%b ready=%b",
                         k, LED, wrap_pulse, cfg_ready, m_led_vec(), m_wrap_vec(), m_ready);
            end
        end
    endtask

    task automatic test_restart_vs_write();
        cfg_write(0, 2, 5, 1);
        if (!m_ready) tick();
        repeat (3) tick();
        sync_restart = 1'b1;
        cfg_valid = 1'b1; cfg_chan = 4'd1; cfg_mode = 2'd2; cfg_half = CW'(3); cfg_burst = 4'd1;
        tick();
        sync_restart = 1'b0; cfg_valid = 1'b0;
        n_tests++;
        if (LED !== '0 || wrap_pulse !== '0) begin
            n_fail++;
            $display("FAIL restart_clear LED=%b wrap=%b expected 0 0", LED, wrap_pulse);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3 || k == 5) begin
                n_tests++;
                if ((k == 3 && (wrap_pulse[1] !== 1'b1 || LED[1] !== 1'b1 || LED[0] !== 1'b0)) ||
                    (k == 5 && (wrap_pulse[0] !== 1'b1 || LED[0] !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL restart_phase cyc%0d LED=%b wrap=%b", k, LED, wrap_pulse);
                end
            end
            n_tests++;
            if (LED !== m_led_vec() || wrap_pulse !== m_wrap_vec()) begin
                n_fail++;
                $display("FAIL restart_model cyc%0d LED=%b wrap=%b expected LED=%b wrap=%b",
                         k, LED, wrap_pulse, m_led_vec(), m_wrap_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_chan     = 4'($urandom_range(0, 9));
            cfg_mode     = 2'($urandom_range(0, 3));
            cfg_half     = CW'($urandom_range(0, 6));
            cfg_burst    = 4'($urandom_range(0, 3));
            sync_restart = ($urandom_range(0, 39) == 0);
            tick();
            n_tests++;
            if (LED !== m_led_vec() || wrap_pulse !== m_wrap_vec() || cfg_ready !== m_ready) begin
                n_fail++;
                $display("FAIL random cyc%0d LED=%b wrap=%b ready=%b expected LED=%b wrap=%b ready=%b",
                         k, LED, wrap_pulse, cfg_ready, m_led_vec(), m_wrap_vec(), m_ready);
            end
        end
        cfg_valid = 1'b0; sync_restart = 1'b0;
    endtask

    task automatic test_async_reset();
        int first_rise;
        first_rise = -1;
        cfg_write(1, 1, 5, 1);
        cfg_write(0, 3, 2, 1);
        repeat (6) tick();
        n_tests++;
        if (LED[1] !== 1'b1 || LED[0] !== 1'b0 || LED !== m_led_vec()) begin
            n_fail++;
            $display("FAIL areset_pre LED=%b expected %b with LED[1]=1", LED, m_led_vec());
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (LED !== '0 || wrap_pulse !== '0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate LED=%b wrap=%b ready=%b expected 0 0 0", LED, wrap_pulse, cfg_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_init();
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (first_rise < 0 && LED[0] === 1'b1) first_rise = k;
            n_tests++;
            if (LED !== m_led_vec() || wrap_pulse !== m_wrap_vec() || cfg_ready !== m_ready) begin
                n_fail++;
                $display("FAIL areset_defaults cyc%0d LED=%b wrap=%b ready=%b expected LED=%b wrap=%b ready=%b",
                         k, LED, wrap_pulse, cfg_ready, m_led_vec(), m_wrap_vec(), m_ready);
            end
        end
        n_tests++;
        if (first_rise != 5) begin
            n_fail++;
            $display("FAIL areset_first_rise got cycle %0d expected 5", first_rise);
        end
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0;
        cfg_half = '0; cfg_burst = '0; sync_restart = 1'b0;
        model_init();
        test_reset();
        test_static_modes();
        test_burst();
        test_handshake();
        test_restart_vs_write();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_bank.md
Name: led_blink_bank

Overview:
- Parametrised multi-channel LED blinker; each channel runs an independent half-period counter and a mode.
- Modes: off, on, continuous blink, burst blink.
- Sits between CLOCK_50 and board LEDs. A simple valid/ready config port lets control logic (switch decoder or CPU) retune a channel at run time.
- Supersedes the single fixed-period toggler.

Parameters:
- CHANNELS, 4, number of LED channels (1..16).
- CNT_WIDTH, 26, width of half-period counter and cfg_half.
- DEFAULT_HALF, 25000000, per-channel half period after reset, in clock cycles.
- DEFAULT_MODE, 2, per-channel mode after reset: 0 off, 1 on, 2 blink, 3 burst.
- PAUSE_HALVES, 8, burst-mode pause length, in half periods.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config port can accept.
- cfg_chan  in  4  target channel index.
- cfg_mode  in  2  new mode.
- cfg_half  in  CNT_WIDTH  new half period, in cycles.
- cfg_burst  in  4  toggle pairs per burst (mode 3).
- sync_restart  in  1  re-phase all channels.
- LED  out  CHANNELS  LED drive, bit i = channel i.
- wrap_pulse  out  CHANNELS  one-cycle strobe on every LED toggle of channel i.

Behaviour:
- **Reset (reset=0, async):**
  - Outputs: LED=0, wrap_pulse=0, cfg_ready=0.
  - Every channel: cnt=0, half=DEFAULT_HALF, mode=DEFAULT_MODE, burst_len=1, state=BLINK, burst_cnt=0.
  - First rising edge after release sets cfg_ready=1.
  - Reset mid-burst or mid-write discards everything; no partial state survives.
- **Effective half period:** H = max(half,1). half=0 behaves as 1, so the channel toggles every cycle.
- **Mode 0 (off):** LED[i]=0; cnt held at 0; no wrap_pulse.
- **Mode 1 (on):** LED[i]=1; cnt held at 0; no wrap_pulse.
- **Mode 2 (blink):**
  - cnt increments each cycle.
  - When cnt==H-1: cnt<=0, LED[i] toggles, wrap_pulse[i]=1 for that same cycle.
  - First toggle occurs H cycles after the channel starts (from 0); period is 2H.
- **Mode 3 (burst), FSM per channel:**
  - BLINK: behaves as mode 2 while counting toggles in burst_cnt. After 2*burst_len toggles (LED back to 0): burst_cnt<=0, go to PAUSE.
  - PAUSE: LED held 0, no wrap_pulse. cnt runs PAUSE_HALVES*H cycles, then go to BLINK with cnt=0.
  - burst_len=0 is treated as 1.
- **Config handshake:**
  - A write is accepted on an edge where cfg_valid && cfg_ready.
  - On that edge the target channel loads mode/half/burst_len and clears cnt, LED, burst_cnt, state=BLINK.
  - cfg_ready drops to 0 for exactly the next cycle, then returns to 1. Max one write per 2 cycles.
  - cfg_valid held high through the ready-low cycle is not accepted twice unless still high when ready returns.
  - cfg_chan >= CHANNELS: accepted (ready toggles normally), no state change.
- **sync_restart=1:** every channel sets cnt=0, LED=0, burst_cnt=0, state=BLINK on that edge; mode/half are unchanged.
- **Simultaneous sync_restart and accepted write:** the write's registers load and all channels restart. Result is identical to a write followed by a restart in the same edge.
- **Timing:** all outputs registered; no combinational input-to-output path.
- **Arithmetic:**
  - Counters are CNT_WIDTH+4 bits internally so the pause count PAUSE_HALVES*H cannot overflow for PAUSE_HALVES<=15.
  - Comparisons are unsigned.

Test Plan:
- **Reset defaults:** CHANNELS=4, CNT_WIDTH=10, DEFAULT_HALF=5; release reset.
  - LED[0] first rises exactly 5 cycles after release, period 10.
  - wrap_pulse[0] high on each toggle edge only.
  - cfg_ready=1 one cycle after release.
- **Static modes and zero half period:**
  - Write ch1 mode=1 → LED[1]=1 steady.
  - Write ch2 mode=0 → LED[2]=0 steady, no wrap_pulse[2].
  - Write ch3 mode=2, half=0 → LED[3] toggles every cycle.
- **Burst:** write ch0 mode=3, half=2, burst=2.
  - 4 toggles (8 cycles).
  - Then 16 cycles of LED=0 with no pulses.
  - Then the pattern repeats.
- **Handshake:**
  - Hold cfg_valid=1 for 4 cycles → exactly 2 writes accepted; cfg_ready pattern 1,0,1,0.
  - cfg_chan=9 accepted with no channel changes.
- **Restart vs write:** sync_restart and a ch1 write (half=3) asserted on the same edge.
  - All LEDs=0.
  - Ch0 and ch1 both toggle exactly H cycles later (5 and 3 respectively).
- **Async reset mid-burst:** assert reset low between edges during PAUSE.
  - LED and wrap_pulse go to 0 immediately, without waiting for a clock.
  - After release, defaults apply (mode 2, H=5).
